// File: rtl/mem_pkg.sv
// Shared constants and enums for the memory arbiter.
// Holds MMIO addresses, exit code, read owner and FSM state types.
package mem_pkg;

    localparam logic [31:0] LOG_ADDR  = 32'h1000_0000;
    localparam logic [31:0] EXIT_ADDR = 32'h2000_0000;
    localparam logic [31:0] EXIT_CODE = 32'h075B_CD15;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_D,
        OWN_MMIO
    } owner_e;

    typedef enum logic [0:0] {
        ST_RUN,
        ST_HALT
    } state_e;

endpackage

// File: rtl/mem_arbiter_mmio_decode.sv
// Combinational MMIO address decoder.
// Ports: addr in; is_mmio (logger or exit) and is_exit out.
module mmio_decode #(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] LOG_ADDR  = ADDR_W'(mem_pkg::LOG_ADDR),
    parameter logic [ADDR_W-1:0] EXIT_ADDR = ADDR_W'(mem_pkg::EXIT_ADDR)
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              is_mmio,
    output logic              is_exit
);

    assign is_exit = (addr == EXIT_ADDR);
    assign is_mmio = (addr == LOG_ADDR) || is_exit;

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter (fetch vs data) with MMIO divert and halt.
// Ports: clk/rst, if_* fetch port, d_* data port, mem_* RAM, mmio_*, halted.
module mem_arbiter #(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       MAX_WAIT  = 4,
    parameter logic [ADDR_W-1:0] LOG_ADDR  = ADDR_W'(mem_pkg::LOG_ADDR),
    parameter logic [ADDR_W-1:0] EXIT_ADDR = ADDR_W'(mem_pkg::EXIT_ADDR),
    parameter logic [DATA_W-1:0] EXIT_CODE = DATA_W'(mem_pkg::EXIT_CODE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mmio_we,
    output logic [ADDR_W-1:0] mmio_addr,
    output logic [DATA_W-1:0] mmio_wdata,
    output logic              halted
);

    import mem_pkg::*;

    state_e            state;
    owner_e            owner;
    owner_e            owner_nxt;
    logic [3:0]        wait_cnt;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              is_mmio;
    logic              is_exit;
    logic              run;
    logic              fetch_pri;
    logic              d_rd;
    logic              halt_set;

    mmio_decode #(
        .ADDR_W    (ADDR_W),
        .LOG_ADDR  (LOG_ADDR),
        .EXIT_ADDR (EXIT_ADDR)
    ) u_dec (
        .addr    (d_addr),
        .is_mmio (is_mmio),
        .is_exit (is_exit)
    );

    // Grants are suppressed while in reset as well as when halted.
    assign run       = (state == ST_RUN) && !rst;
    assign fetch_pri = (wait_cnt == 4'(MAX_WAIT));

    assign d_gnt  = run && d_req && !(if_req && fetch_pri);
    assign if_gnt = run && if_req && !d_gnt;

    assign d_rd     = d_gnt && !d_we;
    assign halt_set = d_gnt && d_we && is_exit && (d_wdata == EXIT_CODE);

    assign mem_en    = if_gnt || (d_gnt && !is_mmio);
    assign mem_we    = d_gnt && d_we && !is_mmio;
    assign mem_addr  = if_gnt ? if_addr : d_addr;
    assign mem_wdata = d_wdata;

    assign mmio_we    = d_gnt && d_we && is_mmio;
    assign mmio_addr  = d_addr;
    assign mmio_wdata = d_wdata;

    assign halted = (state == ST_HALT);

    // A read granted just before reset must not surface during reset.
    assign if_rvalid = !rst && (owner == OWN_IF);
    assign d_rvalid  = !rst && ((owner == OWN_D) || (owner == OWN_MMIO));

    always_comb begin
        owner_nxt = OWN_NONE;
        unique case (1'b1)
            if_gnt:           owner_nxt = OWN_IF;
            d_rd && is_mmio:  owner_nxt = OWN_MMIO;
            d_rd && !is_mmio: owner_nxt = OWN_D;
            default:          owner_nxt = OWN_NONE;
        endcase
    end

    // Read data is steered straight from the RAM in the valid cycle,
    // otherwise the last delivered word is held.
    always_comb begin
        if_rdata = if_rdata_q;
        if (rst) begin
            if_rdata = '0;
        end else if (owner == OWN_IF) begin
            if_rdata = mem_rdata;
        end
    end

    always_comb begin
        d_rdata = d_rdata_q;
        if (rst) begin
            d_rdata = '0;
        end else if (owner == OWN_D) begin
            d_rdata = mem_rdata;
        end else if (owner == OWN_MMIO) begin
            d_rdata = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_RUN;
            owner      <= OWN_NONE;
            wait_cnt   <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if (halt_set) begin
                state <= ST_HALT;
            end
            owner <= owner_nxt;
            if (!if_req || if_gnt) begin
                wait_cnt <= '0;
            end else if (!fetch_pri) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
            if (owner == OWN_IF) begin
                if_rdata_q <= mem_rdata;
            end
            if (owner == OWN_D) begin
                d_rdata_q <= mem_rdata;
            end else if (owner == OWN_MMIO) begin
                d_rdata_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed steps plus random traffic
// checked against a cycle-level reference model and a behavioural RAM.
module tb_mem_arbiter;

    localparam logic [31:0] LOG_A  = 32'h1000_0000;
    localparam logic [31:0] EXIT_A = 32'h2000_0000;
    localparam logic [31:0] CODE   = 32'h075B_CD15;
    localparam int          MAXW   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mmio_we;
    logic [31:0] mmio_addr;
    logic [31:0] mmio_wdata;
    logic        halted;

    logic [31:0] ram [256];

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          to_if;
        logic [31:0] data;
    } resp_t;

    resp_t       pend[$];
    int          m_wait;
    bit          m_halt;
    logic [31:0] last_if;
    logic [31:0] last_d;

    mem_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_gnt      (d_gnt),
        .d_rvalid   (d_rvalid),
        .d_rdata    (d_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mmio_we    (mmio_we),
        .mmio_addr  (mmio_addr),
        .mmio_wdata (mmio_wdata),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr[9:2]] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr[9:2]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        m_wait  = 0;
        m_halt  = 0;
        last_if = '0;
        last_d  = '0;
    endtask

    // One clock with reset high; requesters may be active.
    task automatic rst_cycle(input bit ir, input bit dr);
        @(negedge clk);
        rst = 1'b1; if_req = ir; d_req = dr; d_we = 1'b0;
        d_addr = 32'h100; if_addr = 32'h0;
        #1;
        chk("rst_if_gnt", 32'(if_gnt), 0);
        chk("rst_d_gnt", 32'(d_gnt), 0);
        chk("rst_mem_en", 32'(mem_en), 0);
        chk("rst_mmio_we", 32'(mmio_we), 0);
        chk("rst_if_rvalid", 32'(if_rvalid), 0);
        chk("rst_d_rvalid", 32'(d_rvalid), 0);
        model_reset();
    endtask

    // One clock of traffic, every output checked against the model.
    task automatic cyc(input bit ir, input logic [31:0] ia, input bit dr,
                       input bit dw, input logic [31:0] da,
                       input logic [31:0] dd, output bit ig, output bit dg);
        bit    eig, edg, mm, have, ex_if, ex_d;
        resp_t r;
        @(negedge clk);
        rst = 1'b0; if_req = ir; if_addr = ia;
        d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
        #1;
        edg = !m_halt && dr && !(ir && m_wait == MAXW);
        eig = !m_halt && ir && !edg;
        mm  = (da == LOG_A) || (da == EXIT_A);
        have = (pend.size() > 0);
        r = '{1'b0, 32'h0};
        if (have) r = pend.pop_front();
        chk("if_gnt", 32'(if_gnt), 32'(eig));
        chk("d_gnt", 32'(d_gnt), 32'(edg));
        chk("mem_en", 32'(mem_en), 32'(eig || (edg && !mm)));
        if (eig) begin
            chk("mem_we_if", 32'(mem_we), 0);
            chk("mem_addr_if", mem_addr, ia);
        end else if (edg && !mm) begin
            chk("mem_we_d", 32'(mem_we), 32'(dw));
            chk("mem_addr_d", mem_addr, da);
            if (dw) chk("mem_wdata", mem_wdata, dd);
        end
        chk("mmio_we", 32'(mmio_we), 32'(edg && dw && mm));
        chk("mmio_addr", mmio_addr, da);
        chk("mmio_wdata", mmio_wdata, dd);
        chk("halted", 32'(halted), 32'(m_halt));
        ex_if = have && r.to_if;
        ex_d  = have && !r.to_if;
        chk("if_rvalid", 32'(if_rvalid), 32'(ex_if));
        chk("d_rvalid", 32'(d_rvalid), 32'(ex_d));
        if (ex_if) last_if = r.data;
        if (ex_d)  last_d  = r.data;
        chk("if_rdata", if_rdata, last_if);
        chk("d_rdata", d_rdata, last_d);
        if (eig) pend.push_back('{1'b1, ram[ia[9:2]]});
        else if (edg && !dw) pend.push_back('{1'b0, mm ? 32'h0 : ram[da[9:2]]});
        if (edg && dw && da == EXIT_A && dd == CODE) m_halt = 1;
        if (ir && !eig) m_wait = (m_wait < MAXW) ? m_wait + 1 : MAXW;
        else            m_wait = 0;
        ig = if_gnt;
        dg = d_gnt;
    endtask

    initial begin
        bit          ig, dg, ip, dp, dw;
        logic [31:0] ia, da, dd;
        int          sel;
        for (int i = 0; i < 256; i++) ram[i] = 32'hA500_0000 + 32'(i * 3 + 1);
        model_reset();

        rst_cycle(1'b1, 1'b1);
        cyc(0, 0, 0, 0, 0, 0, ig, dg);
        chk("reset_if_rdata", if_rdata, 0);
        chk("reset_halted", 32'(halted), 0);

        // Fetch stream 0x0, 0x4, 0x8.
        for (int i = 0; i < 3; i++) begin
            cyc(1, 32'(i * 4), 0, 0, 0, 0, ig, dg);
            chk("fetch_gnt", 32'(ig), 1);
        end
        cyc(0, 0, 0, 0, 0, 0, ig, dg);
        chk("fetch_last_data", if_rdata, ram[2]);

        // Both requesting: four data grants, then fetch, then data.
        for (int i = 0; i < 6; i++) begin
            cyc(1, 32'h40, 1, 0, 32'h10, 0, ig, dg);
            chk("starve_if", 32'(ig), 32'(i == 4));
            chk("starve_d", 32'(dg), 32'(i != 4));
        end
        cyc(0, 0, 0, 0, 0, 0, ig, dg);

        // Logger store, then non-exit-code store to exit window.
        cyc(0, 0, 1, 1, LOG_A, 32'h41, ig, dg);
        chk("log_mmio_we", 32'(mmio_we), 1);
        chk("log_mmio_wdata", mmio_wdata, 32'h41);
        cyc(0, 0, 1, 1, EXIT_A, 32'h1, ig, dg);
        cyc(0, 0, 0, 0, 0, 0, ig, dg);
        chk("no_halt", 32'(halted), 0);

        // MMIO load returns zero, after a RAM load left nonzero data.
        cyc(0, 0, 1, 0, 32'h20, 0, ig, dg);
        cyc(0, 0, 1, 0, LOG_A, 0, ig, dg);
        chk("mmio_ld_mem_en", 32'(mem_en), 0);
        cyc(0, 0, 0, 0, 0, 0, ig, dg);
        chk("mmio_ld_rvalid", 32'(d_rvalid), 1);
        chk("mmio_ld_rdata", d_rdata, 0);

        // Load then reset on the next cycle: its rvalid is dropped.
        cyc(0, 0, 1, 0, 32'h30, 0, ig, dg);
        cyc(0, 0, 1, 0, 32'h100, 0, ig, dg);
        rst_cycle(1'b0, 1'b0);
        cyc(0, 0, 0, 0, 0, 0, ig, dg);
        chk("midrst_d_rdata", d_rdata, 0);

        // Random traffic; requests held until granted.
        ip = 0; dp = 0; dw = 0; ia = 0; da = 0; dd = 0;
        repeat (400) begin
            if (!ip && $urandom_range(0, 3) != 0) begin
                ip = 1;
                ia = 32'($urandom_range(0, 255)) << 2;
            end
            if (!dp && $urandom_range(0, 2) != 0) begin
                dp  = 1;
                dw  = 1'($urandom_range(0, 1));
                dd  = $urandom;
                if (dd == CODE) dd = dd ^ 32'h1;
                sel = $urandom_range(0, 9);
                if (sel == 0)      da = LOG_A;
                else if (sel == 1) da = EXIT_A;
                else               da = 32'($urandom_range(0, 255)) << 2;
            end
            cyc(ip, ia, dp, dw, da, dd, ig, dg);
            if (ig) ip = 0;
            if (dg) dp = 0;
        end
        cyc(0, 0, 0, 0, 0, 0, ig, dg);

        // Exit code with a competing fetch, then halted.
        cyc(1, 32'h8, 0, 0, 0, 0, ig, dg);
        cyc(1, 32'h8, 1, 1, EXIT_A, CODE, ig, dg);
        chk("exit_d_gnt", 32'(dg), 1);
        chk("exit_if_gnt", 32'(ig), 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 32'h8, 1, 0, 32'h20, 0, ig, dg);
            chk("halt_flag", 32'(halted), 1);
            chk("halt_no_gnt", 32'({ig, dg}), 0);
        end
        rst_cycle(1'b1, 1'b0);
        cyc(0, 0, 0, 0, 0, 0, ig, dg);
        chk("post_rst_halted", 32'(halted), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
